// File: rtl/subpel_array_loader_pkg.sv
// Shared definitions for the sub-pixel interpolation buffer write side.
// Holds the block geometry derived from the output block width, the
// half-sample row type encodings and the loader FSM state type.
package subpel_array_loader_pkg;

  localparam int NUM_PIXEL_DEF = 8;
  localparam int INT_ROWS      = NUM_PIXEL_DEF + 7;    // 15 integer rows/cols
  localparam int ROW_BITS      = INT_ROWS * 8;         // 120 bits per row
  localparam int HALF_ROWS     = NUM_PIXEL_DEF;        // 8 half rows per type
  localparam int INT_BITS      = INT_ROWS * ROW_BITS;  // 1800
  localparam int HALF_BITS     = HALF_ROWS * ROW_BITS; // 960

  typedef enum logic [1:0] {
    HT_NONE = 2'd0,
    HT_A    = 2'd1,
    HT_B    = 2'd2,
    HT_C    = 2'd3
  } half_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_INT  = 2'd1,
    ST_LOAD_HALF = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/subpel_half_bank.sv
// One half-sample row store (8 rows of 120 bits) with its own fill counter.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   clear             - restart the fill counter for a new block
//   wr_req            - a half row of this bank's type was accepted
//   wr_data           - the accepted row
//   rows              - flat storage, row j at [j*ROW_W +: ROW_W]
//   will_fill         - bank is full, or becomes full with this write
//   reject            - wr_req arrived while the bank was already full
module subpel_half_bank
  import subpel_array_loader_pkg::*;
#(
  parameter int ROW_W = ROW_BITS,
  parameter int ROWS  = HALF_ROWS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_req,
  input  logic [ROW_W-1:0]        wr_data,
  output logic [ROWS*ROW_W-1:0]   rows,
  output logic                    will_fill,
  output logic                    reject
);

  logic [3:0]              cnt_r;
  logic [ROWS*ROW_W-1:0]   arr_r;
  logic                    full_s;
  logic                    wr_en_s;

  // Write gating: a full bank drops the row and flags it instead.
  always_comb begin
    full_s    = (cnt_r == 4'(ROWS));
    wr_en_s   = wr_req && !full_s;
    reject    = wr_req && full_s;
    will_fill = full_s || (wr_en_s && (cnt_r == 4'(ROWS - 1)));
  end

  // Row counter: cleared at block start, advances on each stored row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= 4'd0;
    end else if (clear) begin
      cnt_r <= 4'd0;
    end else if (wr_en_s) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Row storage: contents survive a new block and are simply overwritten.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arr_r <= '0;
    end else if (wr_en_s) begin
      arr_r[int'(cnt_r[2:0]) * ROW_W +: ROW_W] <= wr_data;
    end else begin
      arr_r <= arr_r;
    end
  end

  assign rows = arr_r;

endmodule

// File: rtl/subpel_array_loader.sv
// Write side of the sub-pixel interpolation buffer. Loads a 15x15 integer
// block from a byte stream, then collects 8 half-sample rows each of types
// A, B and C, exposing everything as flat arrays for the row/column selector.
// Ports:
//   clock, reset                 - rising-edge clock, async active-low reset
//   start                        - begin a block (only from IDLE or DONE)
//   pix_valid/pix_data/pix_ready - integer pixel stream, raster order
//   half_valid/half_type/half_data/half_ready - half-sample row stream
//   integer_array                - pixel (r,k) at [r*120 + k*8 +: 8]
//   a/b/c_half_array             - row j at [j*120 +: 120]
//   int_done, half_done, busy, err - block status, err is sticky per block
module subpel_array_loader
  import subpel_array_loader_pkg::*;
#(
  parameter int NUM_PIXEL = NUM_PIXEL_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [7:0]             pix_data,
  output logic                   pix_ready,
  input  logic                   half_valid,
  input  logic [1:0]             half_type,
  input  logic [ROW_BITS-1:0]    half_data,
  output logic                   half_ready,
  output logic [INT_BITS-1:0]    integer_array,
  output logic [HALF_BITS-1:0]   a_half_array,
  output logic [HALF_BITS-1:0]   b_half_array,
  output logic [HALF_BITS-1:0]   c_half_array,
  output logic                   int_done,
  output logic                   half_done,
  output logic                   busy,
  output logic                   err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_PIXEL + 6);

  state_e               state_r;
  logic [3:0]           row_r;
  logic [3:0]           col_r;
  logic [INT_BITS-1:0]  int_array_r;

  logic        pix_xfer_s;
  logic        half_xfer_s;
  logic        start_ok_s;
  logic        last_pix_s;
  logic        bad_s;
  logic        all_fill_s;
  logic [10:0] pix_idx_s;
  logic        wr_a_s, wr_b_s, wr_c_s;
  logic        fill_a_s, fill_b_s, fill_c_s;
  logic        rej_a_s, rej_b_s, rej_c_s;

  // Handshake decode; the ready flags are registers, so these are clean.
  always_comb begin
    pix_xfer_s  = pix_valid && pix_ready;
    half_xfer_s = half_valid && half_ready;
    start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    last_pix_s  = pix_xfer_s && (row_r == LAST_IDX) && (col_r == LAST_IDX);
    wr_a_s      = half_xfer_s && (half_type == HT_A);
    wr_b_s      = half_xfer_s && (half_type == HT_B);
    wr_c_s      = half_xfer_s && (half_type == HT_C);
    // Illegal type or overflow into a full bank: row is dropped, err set.
    bad_s       = (half_xfer_s && (half_type == HT_NONE)) ||
                  rej_a_s || rej_b_s || rej_c_s;
    all_fill_s  = fill_a_s && fill_b_s && fill_c_s;
    // Row pitch is 120 bits, pixel pitch 8 bits.
    pix_idx_s   = ({7'd0, row_r} * 11'(ROW_BITS)) + {4'd0, col_r, 3'd0};
  end

  // Block sequencer with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      row_r      <= 4'd0;
      col_r      <= 4'd0;
      pix_ready  <= 1'b0;
      half_ready <= 1'b0;
      busy       <= 1'b0;
      int_done   <= 1'b0;
      half_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            state_r   <= ST_LOAD_INT;
            row_r     <= 4'd0;
            col_r     <= 4'd0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
            int_done  <= 1'b0;
            half_done <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_LOAD_INT: begin
          if (pix_xfer_s) begin
            if (col_r == LAST_IDX) begin
              col_r <= 4'd0;
              row_r <= row_r + 4'd1;
            end else begin
              col_r <= col_r + 4'd1;
            end
            if (last_pix_s) begin
              state_r    <= ST_LOAD_HALF;
              pix_ready  <= 1'b0;
              half_ready <= 1'b1;
              int_done   <= 1'b1;
            end
          end
        end
        ST_LOAD_HALF: begin
          if (half_xfer_s) begin
            if (bad_s) begin
              err <= 1'b1;
            end
            if (all_fill_s) begin
              state_r    <= ST_DONE;
              half_ready <= 1'b0;
              busy       <= 1'b0;
              half_done  <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pix_ready  <= 1'b0;
          half_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Integer sample storage, written in raster order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      int_array_r <= '0;
    end else if (pix_xfer_s) begin
      int_array_r[pix_idx_s +: 8] <= pix_data;
    end else begin
      int_array_r <= int_array_r;
    end
  end

  assign integer_array = int_array_r;

  subpel_half_bank #(.ROW_W(ROW_BITS), .ROWS(HALF_ROWS)) u_bank_a (
    .clock(clock), .reset(reset), .clear(start_ok_s), .wr_req(wr_a_s),
    .wr_data(half_data), .rows(a_half_array), .will_fill(fill_a_s), .reject(rej_a_s)
  );

  subpel_half_bank #(.ROW_W(ROW_BITS), .ROWS(HALF_ROWS)) u_bank_b (
    .clock(clock), .reset(reset), .clear(start_ok_s), .wr_req(wr_b_s),
    .wr_data(half_data), .rows(b_half_array), .will_fill(fill_b_s), .reject(rej_b_s)
  );

  subpel_half_bank #(.ROW_W(ROW_BITS), .ROWS(HALF_ROWS)) u_bank_c (
    .clock(clock), .reset(reset), .clear(start_ok_s), .wr_req(wr_c_s),
    .wr_data(half_data), .rows(c_half_array), .will_fill(fill_c_s), .reject(rej_c_s)
  );

endmodule

// File: tb/tb_subpel_array_loader.sv
// Self-checking bench for subpel_array_loader: randomized streams against a
// block-level reference model, compared on every falling edge, plus literal
// spot checks that pin the model.
module tb_subpel_array_loader;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'd0;
  logic          pix_ready;
  logic          half_valid = 1'b0;
  logic [1:0]    half_type = 2'd0;
  logic [119:0]  half_data = 120'd0;
  logic          half_ready;
  logic [1799:0] integer_array;
  logic [959:0]  a_half_array, b_half_array, c_half_array;
  logic          int_done, half_done, busy, err;

  subpel_array_loader #(.NUM_PIXEL(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .half_valid(half_valid), .half_type(half_type), .half_data(half_data),
    .half_ready(half_ready), .integer_array(integer_array),
    .a_half_array(a_half_array), .b_half_array(b_half_array),
    .c_half_array(c_half_array), .int_done(int_done), .half_done(half_done),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int n_comp = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 integer load, 2 half load, 3 done.
  int           ph;
  int           npix;
  int           cnt [0:3];
  logic [7:0]   m_int [0:224];
  logic [119:0] m_half [0:3][0:7];
  bit           m_int_done, m_half_done, m_err, m_acc;
  int           dut_pix_xfers;

  task automatic model_reset();
    ph = 0; npix = 0; m_int_done = 0; m_half_done = 0; m_err = 0; m_acc = 0;
    for (int t = 0; t < 4; t++) begin
      cnt[t] = 0;
      for (int j = 0; j < 8; j++) m_half[t][j] = '0;
    end
    for (int k = 0; k < 225; k++) m_int[k] = 8'd0;
  endtask

  task automatic model_update();
    int t;
    m_acc = 0;
    if (ph == 0 || ph == 3) begin
      if (start) begin
        ph = 1; npix = 0; m_int_done = 0; m_half_done = 0; m_err = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end
    end else if (ph == 1) begin
      if (pix_valid) begin
        m_acc = 1;
        m_int[npix] = pix_data;
        npix++;
        if (npix == 225) begin ph = 2; m_int_done = 1; end
      end
    end else begin
      if (half_valid) begin
        m_acc = 1;
        t = int'(half_type);
        if (t == 0 || cnt[t] == 8) m_err = 1;
        else begin
          m_half[t][cnt[t]] = half_data;
          cnt[t]++;
        end
        if (cnt[1] == 8 && cnt[2] == 8 && cnt[3] == 8) begin ph = 3; m_half_done = 1; end
      end
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_comp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_comp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_int_arr(input logic [1799:0] act, input logic [1799:0] exp);
    n_comp++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < 225; k++) begin
        if (act[k*8 +: 8] !== exp[k*8 +: 8]) begin
          $display("FAIL integer_array at %0t: byte %0d got %h want %h", $time, k, act[k*8 +: 8], exp[k*8 +: 8]);
          break;
        end
      end
    end
  endtask

  task automatic cmp_half_arr(input string name, input logic [959:0] act, input logic [959:0] exp);
    n_comp++;
    if (act !== exp) begin
      n_fail++;
      for (int j = 0; j < 8; j++) begin
        if (act[j*120 +: 120] !== exp[j*120 +: 120]) begin
          $display("FAIL %s at %0t: row %0d got %h want %h", name, $time, j, act[j*120 +: 120], exp[j*120 +: 120]);
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [1799:0] e_int;
    logic [959:0]  e_h [1:3];
    for (int k = 0; k < 225; k++) e_int[k*8 +: 8] = m_int[k];
    for (int t = 1; t < 4; t++)
      for (int j = 0; j < 8; j++) e_h[t][j*120 +: 120] = m_half[t][j];
    cmp1("pix_ready", pix_ready, ph == 1);
    cmp1("half_ready", half_ready, ph == 2);
    cmp1("busy", busy, ph == 1 || ph == 2);
    cmp1("int_done", int_done, m_int_done);
    cmp1("half_done", half_done, m_half_done);
    cmp1("err", err, m_err);
    cmp_int_arr(integer_array, e_int);
    cmp_half_arr("a_half_array", a_half_array, e_h[1]);
    cmp_half_arr("b_half_array", b_half_array, e_h[2]);
    cmp_half_arr("c_half_array", c_half_array, e_h[3]);
  endtask

  // One clock: inputs are stable from the previous falling edge.
  task automatic tick();
    if (pix_valid && pix_ready) dut_pix_xfers++;
    @(posedge clock);
    if (reset) model_update();
    else m_acc = 0;
    @(negedge clock);
    check_all();
  endtask

  function automatic logic [119:0] rand120();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[119:0];
  endfunction

  function automatic logic [119:0] pattern(input int t, input int j);
    logic [7:0] b;
    b = {4'(t), 4'(j)};
    return {15{b}};
  endfunction

  task automatic fail_timeout(input string name);
    n_comp++;
    n_fail++;
    $display("FAIL %s timeout at %0t: got no progress want completion", name, $time);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed integer pixels; mode 0 data = index, mode 1 data = index*7+3.
  task automatic load_int(input bit gaps, input bit noise, input int start_at,
                          input int stop_at, input int mode);
    int c = 0;
    while (ph == 1 && npix != stop_at) begin
      if (c > 3000) begin fail_timeout("load_int"); break; end
      pix_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_data   = (mode == 0) ? 8'(npix) : 8'(npix * 7 + 3);
      half_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      half_type  = 2'($urandom);
      half_data  = rand120();
      start      = (c == start_at);
      tick();
      c++;
    end
    pix_valid = 1'b0; half_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send_half(input int t, input logic [119:0] d);
    int c = 0;
    int gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      half_valid = 1'b0;
      pix_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    half_valid = 1'b1; half_type = 2'(t); half_data = d;
    pix_valid  = 1'($urandom_range(0, 1));
    tick();
    while (!m_acc) begin
      if (c > 50) begin fail_timeout("send_half"); break; end
      tick();
      c++;
    end
    half_valid = 1'b0; pix_valid = 1'b0;
  endtask

  // 24 rows, 8 per type, in shuffled order; data pattern or random.
  task automatic load_half_shuffled(input bit rnd);
    int order [0:23];
    int tmp, r, t;
    for (int i = 0; i < 24; i++) order[i] = (i % 3) + 1;
    for (int i = 23; i > 0; i--) begin
      r = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[r]; order[r] = tmp;
    end
    for (int i = 0; i < 24; i++) begin
      t = order[i];
      send_half(t, rnd ? rand120() : pattern(t, cnt[t]));
    end
  endtask

  initial begin
    model_reset();
    dut_pix_xfers = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) tick();
    cmp1("rst_int_zero", integer_array == '0, 1'b1);
    cmp1("rst_halves_zero", (a_half_array | b_half_array | c_half_array) == '0, 1'b1);
    cmp1("rst_flags", int_done | half_done | busy | err | pix_ready | half_ready, 1'b0);

    // Block 1: gap-free integer load, value = index.
    do_start();
    load_int(1'b0, 1'b0, -1, -1, 0);
    cmp8("int_first_byte", integer_array[7:0], 8'h00);
    cmp8("int_last_byte", integer_array[1799:1792], 8'hE0);
    cmp1("int_done_after_225", int_done, 1'b1);
    cmp1("half_ready_after_225", half_ready, 1'b1);
    cmp1("pix_ready_after_225", pix_ready, 1'b0);
    load_half_shuffled(1'b0);
    cmp1("half_done_after_24", half_done, 1'b1);
    cmp1("half_ready_after_24", half_ready, 1'b0);
    cmp8("b_row3_byte", b_half_array[3*120 +: 8], 8'h23);
    cmp8("c_row7_byte", c_half_array[7*120 +: 8], 8'h37);

    // Block 2: gaps, half_valid noise, ignored start; overflow and illegal rows.
    dut_pix_xfers = 0;
    do_start();
    load_int(1'b1, 1'b1, 40, -1, 0);
    cmp1("xfer_count_225", dut_pix_xfers == 225, 1'b1);
    cmp8("gap_first_byte", integer_array[7:0], 8'h00);
    cmp8("gap_last_byte", integer_array[1799:1792], 8'hE0);
    for (int i = 0; i < 8; i++) begin
      send_half(1, pattern(5, i));
      if (i < 4) send_half(2, pattern(6, i));
      if (i < 4) send_half(3, pattern(7, i));
    end
    send_half(1, {120{1'b1}});
    cmp1("err_after_overflow", err, 1'b1);
    send_half(0, rand120());
    cmp1("err_after_illegal", err, 1'b1);
    cmp1("still_load_half", half_ready & busy, 1'b1);
    cmp8("a_row0_kept", a_half_array[7:0], 8'h50);
    cmp8("a_row7_kept", a_half_array[7*120 +: 8], 8'h57);
    for (int i = 4; i < 8; i++) begin
      send_half(2, pattern(6, i));
      send_half(3, pattern(7, i));
    end
    cmp1("half_done_block2", half_done, 1'b1);

    // Block 3: reset at pixel 100, then a fresh block.
    do_start();
    load_int(1'b1, 1'b0, -1, 100, 1);
    reset = 1'b0;
    #1;
    cmp1("async_rst_int_zero", integer_array == '0, 1'b1);
    cmp1("async_rst_halves_zero", (a_half_array | b_half_array | c_half_array) == '0, 1'b1);
    cmp1("async_rst_flags", int_done | half_done | busy | err | pix_ready | half_ready, 1'b0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    pix_valid = 1'b1;
    repeat (2) tick();
    pix_valid = 1'b0;
    do_start();
    load_int(1'b1, 1'b1, -1, -1, 1);
    cmp8("fresh_first_byte", integer_array[7:0], 8'h03);
    cmp8("fresh_last_byte", integer_array[1799:1792], 8'h23);
    load_half_shuffled(1'b1);
    cmp1("half_done_block3", half_done, 1'b1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
